// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master, single-slave arbiter for the shared data bus.
// Master 0 is the core data port and master 1 is the debug/program loader.
// One single-beat transaction is in flight at a time. Masters are served
// round-robin, and each response is routed back to the master that owns it.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   mN_req/we/be/addr/wdata   master N request; held stable until mN_gnt
//   mN_gnt               1-cycle grant pulse, combinational in IDLE
//   mN_rvalid, mN_rdata  1-cycle completion pulse and held read data
//   s_req/we/be/addr/wdata    registered request to the slave
//   s_gnt, s_rvalid, s_rdata  slave accept and response
//   busy                 high whenever the arbiter is not in IDLE
//   mN_err               timeout pulse alongside mN_rvalid (DBUS_TIMEOUT_EN only)
//
// Optional feature macro: DBUS_TIMEOUT_EN. When it is defined, the arbiter
// force-completes a transaction after TIMEOUT cycles in ISSUE/WAIT. The
// forced response returns 32'hDEAD_BEEF and pulses mN_err.
module dbus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DW/8-1:0]   m0_be,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DW/8-1:0]   m1_be,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [DW/8-1:0]   s_be,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic              s_gnt,
  input  logic              s_rvalid,
  input  logic [DW-1:0]     s_rdata,
`ifdef DBUS_TIMEOUT_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          prio;      // preferred master when both request
  logic          owner;     // master that owns the transaction in flight
  logic          any_req_c;
  logic          win_c;
  logic          done_c;
  logic          tmo_c;
  logic [DW-1:0] rsp_data_c;

  // Winner: the lone requester, or the preferred master under contention.
  assign any_req_c = m0_req | m1_req;
  assign win_c     = (m0_req & m1_req) ? prio : m1_req;

  // Grant pulses only in IDLE, in the same cycle the request is seen.
  assign m0_gnt = !reset && (state == IDLE) && any_req_c && !win_c;
  assign m1_gnt = !reset && (state == IDLE) && any_req_c &&  win_c;

  // Slave response that ends the transaction. An s_rvalid in ISSUE that
  // arrives without s_gnt is spurious and is ignored.
  assign done_c = s_rvalid && (((state == ISSUE) && s_gnt) || (state == WAIT));

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] tmo_cnt;

  // A real response takes precedence over a timeout in the same cycle.
  assign tmo_c      = ((state == ISSUE) || (state == WAIT)) && !done_c &&
                      (tmo_cnt == CW'(TIMEOUT - 1));
  assign rsp_data_c = done_c ? s_rdata : DW'(32'hDEAD_BEEF);
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign tmo_c      = 1'b0;
  assign rsp_data_c = s_rdata;
`endif

  // Arbitration FSM with registered slave request, response and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      s_req     <= 1'b0;
      s_we      <= 1'b0;
      s_be      <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      busy      <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      tmo_cnt   <= '0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      if ((state == ISSUE) || (state == WAIT)) tmo_cnt <= tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (any_req_c) begin
            owner   <= win_c;
            s_req   <= 1'b1;
            s_we    <= win_c ? m1_we    : m0_we;
            s_be    <= win_c ? m1_be    : m0_be;
            s_addr  <= win_c ? m1_addr  : m0_addr;
            s_wdata <= win_c ? m1_wdata : m0_wdata;
            busy    <= 1'b1;
            state   <= ISSUE;
`ifdef DBUS_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        ISSUE: begin
          if (s_gnt) begin
            s_req <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: ;
        RESP: begin
          prio  <= ~owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Completion (normal or forced) overrides the per-state updates above.
      if (done_c || tmo_c) begin
        state <= RESP;
        s_req <= 1'b0;
        if (owner) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= rsp_data_c;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= rsp_data_c;
        end
`ifdef DBUS_TIMEOUT_EN
        m0_err <= tmo_c && !owner;
        m1_err <= tmo_c &&  owner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: randomized bench for dbus_arbiter. Random masters and a
// random-latency slave drive the arbiter. A transaction-level model of the
// arbitration and response rules predicts every output, cycle by cycle.
module tb_dbus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [BW-1:0] m0_be;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [BW-1:0] m1_be;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          s_req, s_we, s_gnt, s_rvalid;
  logic [BW-1:0] s_be;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          busy;
`ifdef DBUS_TIMEOUT_EN
  logic          m0_err, m1_err;
`endif

  dbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
`ifdef DBUS_TIMEOUT_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Master-side transaction model
  logic          pend [2];
  logic          wait_rsp [2];
  logic          t_we [2];
  logic [BW-1:0] t_be [2];
  logic [AW-1:0] t_addr [2];
  logic [DW-1:0] t_wdata [2];
  logic [DW-1:0] exp_rdata [2];
  int            done_cnt [2];
  int unsigned   req_pct;

  // Arbiter-level model: in_flight spans the cycle after a grant through the response cycle
  logic          in_flight;
  int            owner, pref, age;
  logic          resp_next, resp_err;
  int            resp_m;
  logic [DW-1:0] resp_data;

  // Slave bus model
  int            sl_state, sl_gdly, sl_rdly;
  logic          sl_mute, sl_hold;
  int            err_seen;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; wait_rsp[m] = 1'b0; exp_rdata[m] = '0;
    end
    in_flight = 1'b0; owner = 0; pref = 0; age = 0;
    resp_next = 1'b0; resp_err = 1'b0; resp_m = 0; resp_data = '0;
    sl_state = 0; sl_gdly = 0; sl_rdly = 0; sl_hold = 1'b0;
  endtask

  task automatic new_txn(input int m);
    pend[m]    = 1'b1;
    t_we[m]    = 1'($urandom_range(0, 1));
    t_be[m]    = BW'($urandom);
    t_addr[m]  = AW'({$urandom_range(0, 255), 2'b00});
    t_wdata[m] = DW'($urandom);
  endtask

  // One bus cycle; entered and left 1 time unit after a rising edge.
  task automatic step();
    logic [1:0] exp_rv, exp_g;
    logic       done_now, real_rsp, exp_sreq;
    int         gm;

    exp_rv = resp_next ? ((resp_m == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("rvalid", 128'({m1_rvalid, m0_rvalid}), 128'(exp_rv));
`ifdef DBUS_TIMEOUT_EN
    check("err", 128'({m1_err, m0_err}), 128'((resp_next && resp_err) ? exp_rv : 2'b00));
    if (m0_err || m1_err) err_seen++;
`endif
    if (resp_next) begin
      exp_rdata[resp_m] = resp_data;
      done_cnt[resp_m]++;
    end
    check("m0_rdata", 128'(m0_rdata), 128'(exp_rdata[0]));
    check("m1_rdata", 128'(m1_rdata), 128'(exp_rdata[1]));
    check("busy", 128'(busy), 128'(in_flight));
    exp_sreq = in_flight && (sl_state == 0) && !resp_next;
    check("s_req", 128'(s_req), 128'(exp_sreq));
    if (exp_sreq)
      check("s_fields", 128'({s_we, s_be, s_addr, s_wdata}),
            128'({t_we[owner], t_be[owner], t_addr[owner], t_wdata[owner]}));
    done_now = resp_next;

    // Masters start a new transaction only after their previous one returns
    for (int m = 0; m < 2; m++)
      if (!pend[m] && !wait_rsp[m] && $urandom_range(0, 99) < req_pct) new_txn(m);
    m0_req = pend[0]; m0_we = t_we[0]; m0_be = t_be[0]; m0_addr = t_addr[0]; m0_wdata = t_wdata[0];
    m1_req = pend[1]; m1_we = t_we[1]; m1_be = t_be[1]; m1_addr = t_addr[1]; m1_wdata = t_wdata[1];

    // Slave: random accept delay, random response delay, stray s_rvalid when nothing is accepted
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = DW'($urandom); real_rsp = 1'b0;
    if (in_flight && !done_now) age++;
    if (sl_state == 1) begin
      sl_rdly--;
      if (sl_rdly == 0) begin s_rvalid = 1'b1; sl_state = 0; real_rsp = 1'b1; end
    end else if (s_req && !sl_mute) begin
      if (sl_gdly == 0) begin
        s_gnt = 1'b1;
        sl_rdly = sl_hold ? 1000 : $urandom_range(0, 2);
        if (sl_rdly == 0) begin s_rvalid = 1'b1; real_rsp = 1'b1; end
        else sl_state = 1;
      end else begin
        sl_gdly--;
        if ($urandom_range(0, 3) == 0) s_rvalid = 1'b1;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      s_rvalid = 1'b1;
    end

    resp_next = 1'b0; resp_err = 1'b0;
    if (real_rsp) begin
      resp_next = 1'b1; resp_m = owner; resp_data = s_rdata;
      sl_gdly = $urandom_range(0, 3);
    end
`ifdef DBUS_TIMEOUT_EN
    else if (in_flight && !done_now && age == TO) begin
      resp_next = 1'b1; resp_err = 1'b1; resp_m = owner; resp_data = 32'hDEAD_BEEF;
    end
`endif

    // Grant: only when idle; lone requester wins, else the preferred master
    #1;
    exp_g = 2'b00;
    if (!in_flight && (pend[0] || pend[1]))
      exp_g = (pend[0] && pend[1]) ? ((pref == 1) ? 2'b10 : 2'b01) : {pend[1], pend[0]};
    check("gnt", 128'({m1_gnt, m0_gnt}), 128'(exp_g));

    if (done_now) begin
      in_flight = 1'b0; wait_rsp[owner] = 1'b0; pref = 1 - owner;
    end
    if (exp_g != 2'b00) begin
      gm = exp_g[1] ? 1 : 0;
      owner = gm; pend[gm] = 1'b0; wait_rsp[gm] = 1'b1; in_flight = 1'b1; age = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic load_read(input int m, input logic [AW-1:0] a);
    pend[m] = 1'b1; t_we[m] = 1'b0; t_be[m] = '1; t_addr[m] = a; t_wdata[m] = '0;
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    sl_mute = 1'b0; err_seen = 0; req_pct = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_slave_side", 128'({s_req, s_we, s_be, s_addr, s_wdata}), 128'(0));
    check("reset_master_side", 128'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, m0_rdata, m1_rdata}), 128'(0));
    reset = 1'b0;

    // Continuous contention from reset, then mixed random traffic
    req_pct = 100;
    repeat (60) step();
    req_pct = 40;
    repeat (1500) step();
    req_pct = 0;
    repeat (30) step();

    // Reset while in WAIT: the aborted transaction never responds
    load_read(0, 32'h1000_0004);
    sl_hold = 1'b1; sl_gdly = 0;
    repeat (3) step();
    check("pre_reset_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_s_req", 128'(s_req), 128'(0));
    check("rst_rvalid", 128'({m1_rvalid, m0_rvalid}), 128'(0));
    reset = 1'b0;
    model_reset();
    d0 = done_cnt[0];
    load_read(0, 32'h1000_0004);
    repeat (12) step();
    check("post_reset_m0_done", 128'(done_cnt[0] - d0), 128'(1));

`ifdef DBUS_TIMEOUT_EN
    // Slave never answers: forced completion with error
    sl_mute = 1'b1; err_seen = 0;
    load_read(0, 32'h1000_0008);
    repeat (TO + 4) step();
    check("tmo_err_pulses", 128'(err_seen), 128'(1));
    check("tmo_rdata", 128'(m0_rdata), 128'(32'hDEAD_BEEF));
    check("tmo_idle", 128'(busy), 128'(0));
    sl_mute = 1'b0;
`endif

    req_pct = 60;
    repeat (400) step();
    check("m0_traffic", 128'(done_cnt[0] > 50), 128'(1));
    check("m1_traffic", 128'(done_cnt[1] > 50), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
